// File: rtl/io_port_arbiter_if.sv
// Requester-side handshake bundle for io_port_arbiter.
// One instance per requester.
//   req   : transaction request (level), held until ack
//   we    : direction, 1 = write, 0 = read
//   addr  : 4-bit register address
//   wdata : write data
//   ack   : one-cycle completion pulse from the arbiter
//   rdata : read data, valid with ack, held until the next read by this requester
// The master modport is the requester view; the slave modport is the arbiter view.
interface io_port_arbiter_if;
  logic       req;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/io_port_arbiter.sv
// Two-requester round-robin arbiter for the shared 4-bit-address / 8-bit-data
// register port of the basic I/O block. Requester 0 is the AVR core's I/O
// space, requester 1 an auxiliary master. One transaction at a time: the
// winner's address/direction/data are registered onto the device port for
// ACCESS_CYCLES cycles, read data is captured on the last access cycle, and
// the winner receives a one-cycle ack.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   m0, m1       : requester handshakes (io_port_arbiter_if.slave)
//   io_addr      : device register address (0 when idle)
//   io_data_in   : device write data (0 unless writing)
//   io_data_out  : device read data, combinational on io_addr/io_re
//   io_re, io_we : device strobes, at most one high
//   busy         : high in ACCESS and ACK
//   gnt_id       : requester currently or most recently served
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; requests sampled and arbitrated every edge
// ACCESS | device strobe active; counter runs down to 0
// ACK    | winner's ack high for one cycle; no arbitration here
module io_port_arbiter #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  io_port_arbiter_if.slave m0,
  io_port_arbiter_if.slave m1,
  output logic [3:0]       io_addr,
  output logic [7:0]       io_data_in,
  input  logic [7:0]       io_data_out,
  output logic             io_re,
  output logic             io_we,
  output logic             busy,
  output logic             gnt_id
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_param_check
    $error("io_port_arbiter: ACCESS_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] io_addr_d;
  logic [7:0] io_data_in_d;
  logic       io_re_d, io_we_d;
  logic       busy_d, gnt_id_d;
  logic       ack0_d, ack1_d;
  logic [7:0] rdata0_d, rdata1_d;

  // Winner of an IDLE-cycle arbitration. On contention the requester that
  // was not served last wins; gnt_id resets to 1 so requester 0 takes the
  // first contention after reset.
  logic       win;
  logic       win_we;
  logic [3:0] win_addr;
  logic [7:0] win_wdata;

  assign win       = (m0.req && m1.req) ? ~gnt_id : m1.req;
  assign win_we    = win ? m1.we    : m0.we;
  assign win_addr  = win ? m1.addr  : m0.addr;
  assign win_wdata = win ? m1.wdata : m0.wdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    io_addr_d    = io_addr;
    io_data_in_d = io_data_in;
    io_re_d      = io_re;
    io_we_d      = io_we;
    busy_d       = busy;
    gnt_id_d     = gnt_id;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = m0.rdata;
    rdata1_d     = m1.rdata;

    case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          // The registered device-port outputs double as the latched
          // request, so later changes on the requester inputs are ignored.
          gnt_id_d     = win;
          cnt_d        = CNT_LOAD;
          io_addr_d    = win_addr;
          io_we_d      = win_we;
          io_re_d      = ~win_we;
          io_data_in_d = win_we ? win_wdata : 8'h00;
          busy_d       = 1'b1;
          state_d      = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (io_re) begin
            if (gnt_id) rdata1_d = io_data_out;
            else        rdata0_d = io_data_out;
          end
          ack0_d       = ~gnt_id;
          ack1_d       = gnt_id;
          io_addr_d    = 4'h0;
          io_data_in_d = 8'h00;
          io_re_d      = 1'b0;
          io_we_d      = 1'b0;
          state_d      = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        io_addr_d    = 4'h0;
        io_data_in_d = 8'h00;
        io_re_d      = 1'b0;
        io_we_d      = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      io_addr    <= 4'h0;
      io_data_in <= 8'h00;
      io_re      <= 1'b0;
      io_we      <= 1'b0;
      busy       <= 1'b0;
      gnt_id     <= 1'b1;
      m0.ack     <= 1'b0;
      m1.ack     <= 1'b0;
      m0.rdata   <= 8'h00;
      m1.rdata   <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      io_addr    <= io_addr_d;
      io_data_in <= io_data_in_d;
      io_re      <= io_re_d;
      io_we      <= io_we_d;
      busy       <= busy_d;
      gnt_id     <= gnt_id_d;
      m0.ack     <= ack0_d;
      m1.ack     <= ack1_d;
      m0.rdata   <= rdata0_d;
      m1.rdata   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// Bench for io_port_arbiter: two instances (ACCESS_CYCLES = 1 and 3) with a
// table-driven device model, checked every cycle against a transaction-level
// reference model built on start-edge timestamps.
module tb_io_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n      [2];
  logic       req        [2][2];
  logic       we         [2][2];
  logic [3:0] addr       [2][2];
  logic [7:0] wdata      [2][2];
  logic       ack        [2][2];
  logic [7:0] rdata      [2][2];
  logic [3:0] io_addr    [2];
  logic [7:0] io_data_in [2];
  logic [7:0] io_data_out[2];
  logic       io_re      [2];
  logic       io_we      [2];
  logic       busy       [2];
  logic       gnt_id     [2];
  logic [7:0] dev_tab    [2][16];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    io_port_arbiter_if m0_if ();
    io_port_arbiter_if m1_if ();

    assign m0_if.req   = req[g][0];
    assign m0_if.we    = we[g][0];
    assign m0_if.addr  = addr[g][0];
    assign m0_if.wdata = wdata[g][0];
    assign m1_if.req   = req[g][1];
    assign m1_if.we    = we[g][1];
    assign m1_if.addr  = addr[g][1];
    assign m1_if.wdata = wdata[g][1];
    assign ack[g][0]   = m0_if.ack;
    assign ack[g][1]   = m1_if.ack;
    assign rdata[g][0] = m0_if.rdata;
    assign rdata[g][1] = m1_if.rdata;

    assign io_data_out[g] = io_re[g] ? dev_tab[g][io_addr[g]] : 8'h00;

    io_port_arbiter #(.ACCESS_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .m0         (m0_if),
      .m1         (m1_if),
      .io_addr    (io_addr[g]),
      .io_data_in (io_data_in[g]),
      .io_data_out(io_data_out[g]),
      .io_re      (io_re[g]),
      .io_we      (io_we[g]),
      .busy       (busy[g]),
      .gnt_id     (gnt_id[g])
    );
  end

  function automatic int ac_of(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // ---------------- reference model ----------------
  // A transaction started on edge s is on the device port after edges
  // s..s+AC-1, acked after edge s+AC, and the next arbitration edge is s+AC+2.
  int         cyc = 0;
  bit         m_act [2];
  int         m_s   [2];
  bit         m_win [2];
  bit         m_we  [2];
  logic [3:0] m_addr[2];
  logic [7:0] m_wd  [2];
  bit         m_last[2];
  logic [7:0] m_rd  [2][2];

  bit         e_re  [2];
  bit         e_we  [2];
  bit         e_busy[2];
  bit         e_ack [2][2];
  logic [3:0] e_addr[2];
  logic [7:0] e_din [2];

  task automatic model_reset(int g);
    m_act[g]   = 1'b0;
    m_s[g]     = 0;
    m_last[g]  = 1'b1;
    m_rd[g][0] = 8'h00;
    m_rd[g][1] = 8'h00;
  endtask

  task automatic model_step(int g);
    int  n, off;
    bit  strobe;
    n = ac_of(g);
    if (!rst_n[g]) begin
      model_reset(g);
    end else begin
      if (m_act[g] && cyc == m_s[g] + n && !m_we[g])
        m_rd[g][m_win[g]] = dev_tab[g][m_addr[g]];
      if (m_act[g] && cyc >= m_s[g] + n + 2)
        m_act[g] = 1'b0;
      if (!m_act[g] && (req[g][0] || req[g][1])) begin
        m_win[g]  = (req[g][0] && req[g][1]) ? !m_last[g] : req[g][1];
        m_we[g]   = we[g][m_win[g]];
        m_addr[g] = addr[g][m_win[g]];
        m_wd[g]   = wdata[g][m_win[g]];
        m_s[g]    = cyc;
        m_act[g]  = 1'b1;
        m_last[g] = m_win[g];
      end
    end
    off         = cyc - m_s[g];
    strobe      = m_act[g] && off < n;
    e_re[g]     = strobe && !m_we[g];
    e_we[g]     = strobe && m_we[g];
    e_addr[g]   = strobe ? m_addr[g] : 4'h0;
    e_din[g]    = (strobe && m_we[g]) ? m_wd[g] : 8'h00;
    e_busy[g]   = m_act[g] && off <= n;
    e_ack[g][0] = m_act[g] && off == n && m_win[g] == 1'b0;
    e_ack[g][1] = m_act[g] && off == n && m_win[g] == 1'b1;
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) model_step(g);
  end

  // ---------------- checking ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  int         re_cnt   [2];
  int         we_cnt   [2];
  int         ack_cnt  [2][2];
  logic [3:0] we_addr  [2];
  logic [7:0] we_din   [2];
  int         order0[$];

  task automatic check_cycle();
    for (int g = 0; g < 2; g++) begin
      check_val($sformatf("g%0d_io_re", g),      io_re[g],      e_re[g]);
      check_val($sformatf("g%0d_io_we", g),      io_we[g],      e_we[g]);
      check_val($sformatf("g%0d_io_addr", g),    io_addr[g],    e_addr[g]);
      check_val($sformatf("g%0d_io_data_in", g), io_data_in[g], e_din[g]);
      check_val($sformatf("g%0d_busy", g),       busy[g],       e_busy[g]);
      check_val($sformatf("g%0d_gnt_id", g),     gnt_id[g],     m_last[g]);
      for (int m = 0; m < 2; m++) begin
        check_val($sformatf("g%0d_m%0d_ack", g, m),   ack[g][m],   e_ack[g][m]);
        check_val($sformatf("g%0d_m%0d_rdata", g, m), rdata[g][m], m_rd[g][m]);
        if (ack[g][m] === 1'b1) begin
          ack_cnt[g][m]++;
          if (g == 0) order0.push_back(m);
        end
      end
      if (io_re[g] === 1'b1) re_cnt[g]++;
      if (io_we[g] === 1'b1) begin
        we_cnt[g]++;
        we_addr[g] = io_addr[g];
        we_din[g]  = io_data_in[g];
      end
    end
  endtask

  // ---------------- requester drivers ----------------
  // mode 0: directed, drops req at ack; 1: random; 2: back-to-back.
  int mode[2][2];
  bit pend[2][2];

  task automatic new_txn(int g, int m);
    pend[g][m]  = 1'b1;
    req[g][m]   = 1'b1;
    we[g][m]    = 1'($urandom);
    addr[g][m]  = 4'($urandom);
    wdata[g][m] = 8'($urandom);
  endtask

  task automatic drive();
    for (int g = 0; g < 2; g++) begin
      for (int m = 0; m < 2; m++) begin
        if (!rst_n[g]) continue;
        if (e_ack[g][m]) begin
          pend[g][m] = 1'b0;
          req[g][m]  = 1'b0;
          if (mode[g][m] == 2 || (mode[g][m] == 1 && $urandom_range(0, 3) == 0))
            new_txn(g, m);
        end else if (mode[g][m] == 1) begin
          if (!pend[g][m]) begin
            if ($urandom_range(0, 3) == 0) new_txn(g, m);
          end else if (m_act[g] && m_win[g] == m[0] && (cyc - m_s[g]) < ac_of(g)) begin
            if ($urandom_range(0, 5) == 0) req[g][m] = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
              addr[g][m]  = 4'($urandom);
              wdata[g][m] = 8'($urandom);
              we[g][m]    = 1'($urandom);
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    drive();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic issue(int g, int m, logic w, logic [3:0] a, logic [7:0] d);
    pend[g][m]  = 1'b1;
    req[g][m]   = 1'b1;
    we[g][m]    = w;
    addr[g][m]  = a;
    wdata[g][m] = d;
  endtask

  task automatic wait_ack(input int g, input int m, input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (ack[g][m] !== 1'b1 && n < budget);
    if (ack[g][m] !== 1'b1)
      check_val($sformatf("g%0d_m%0d_ack_timeout", g, m), ack[g][m], 1);
  endtask

  // Called right after a negedge: reset asserts mid-cycle and outputs must
  // return to reset values without waiting for a clock edge.
  task automatic reset_inst(int g);
    rst_n[g] = 1'b0;
    #1;
    check_val($sformatf("g%0d_rst_io_re", g),   io_re[g],   0);
    check_val($sformatf("g%0d_rst_io_we", g),   io_we[g],   0);
    check_val($sformatf("g%0d_rst_io_addr", g), io_addr[g], 0);
    check_val($sformatf("g%0d_rst_busy", g),    busy[g],    0);
    check_val($sformatf("g%0d_rst_gnt_id", g),  gnt_id[g],  1);
    check_val($sformatf("g%0d_rst_ack0", g),    ack[g][0],  0);
    check_val($sformatf("g%0d_rst_rdata0", g),  rdata[g][0], 0);
    model_reset(g);
    for (int m = 0; m < 2; m++) begin
      pend[g][m] = 1'b0;
      req[g][m]  = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, saved;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0;
      model_reset(g);
      re_cnt[g] = 0;
      we_cnt[g] = 0;
      for (int m = 0; m < 2; m++) begin
        req[g][m] = 1'b0; we[g][m] = 1'b0; addr[g][m] = 4'h0; wdata[g][m] = 8'h00;
        mode[g][m] = 0; pend[g][m] = 1'b0; ack_cnt[g][m] = 0;
      end
      for (int a = 0; a < 16; a++) dev_tab[g][a] = 8'h00;
    end
    dev_tab[0][0]  = 8'h5A;
    dev_tab[1][12] = 8'h10;
    dev_tab[1][5]  = 8'hB7;

    run(3);
    check_val("reset_gnt_id", gnt_id[0], 1);
    check_val("reset_busy", busy[0], 0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    run(2);

    // m0 read of 0x0 on the AC=1 instance
    re_cnt[0] = 0; we_cnt[0] = 0;
    issue(0, 0, 1'b0, 4'h0, 8'hFF);
    wait_ack(0, 0, 10, n);
    check_val("rd0_latency", n, 2);
    check_val("rd0_rdata", rdata[0][0], 8'h5A);
    check_val("rd0_re_cycles", re_cnt[0], 1);
    check_val("rd0_we_cycles", we_cnt[0], 0);
    run(2);

    // m1 write of 0xC3 to 0x4
    re_cnt[0] = 0; we_cnt[0] = 0;
    issue(0, 1, 1'b1, 4'h4, 8'hC3);
    wait_ack(0, 1, 10, n);
    check_val("wr1_we_cycles", we_cnt[0], 1);
    check_val("wr1_re_cycles", re_cnt[0], 0);
    check_val("wr1_addr", we_addr[0], 4'h4);
    check_val("wr1_data", we_din[0], 8'hC3);
    check_val("wr1_rdata", rdata[0][1], 8'h00);
    run(2);

    // Simultaneous writes: m0 first, m1 next at minimum spacing
    issue(0, 0, 1'b1, 4'h1, 8'h11);
    issue(0, 1, 1'b1, 4'h2, 8'h22);
    wait_ack(0, 0, 10, n);
    check_val("pair_first_gnt", gnt_id[0], 0);
    wait_ack(0, 1, 10, n);
    check_val("pair_second_spacing", n, 3);
    check_val("pair_second_gnt", gnt_id[0], 1);
    run(2);

    // Both held back-to-back: strict alternation starting with m0
    order0.delete();
    mode[0][0] = 2; mode[0][1] = 2;
    new_txn(0, 0); new_txn(0, 1);
    n = 0;
    while (order0.size() < 8 && n < 100) begin
      cycle();
      n++;
    end
    mode[0][0] = 0; mode[0][1] = 0;
    check_val("alt_count", order0.size() >= 8, 1);
    for (int i = 0; i < 8 && i < order0.size(); i++)
      check_val($sformatf("alt_%0d", i), order0[i], i % 2);
    run(20);

    // AC=3 read of 0xC
    re_cnt[1] = 0;
    issue(1, 0, 1'b0, 4'hC, 8'h00);
    wait_ack(1, 0, 20, n);
    check_val("ac3_latency", n, 4);
    check_val("ac3_re_cycles", re_cnt[1], 3);
    check_val("ac3_rdata", rdata[1][0], 8'h10);
    run(2);

    // m0 drops req (and scrambles addr) during ACCESS
    saved = ack_cnt[1][0];
    issue(1, 0, 1'b1, 4'h2, 8'h77);
    cycle();
    req[1][0] = 1'b0;
    addr[1][0] = 4'hF;
    wait_ack(1, 0, 20, n);
    check_val("drop_latency", n + 1, 4);
    run(8);
    check_val("drop_ack_once", ack_cnt[1][0] - saved, 1);
    check_val("drop_busy_idle", busy[1], 0);

    // Reset during the 2nd ACCESS cycle, m1 pending behind m0
    issue(1, 0, 1'b0, 4'hC, 8'h00);
    cycle();
    issue(1, 1, 1'b0, 4'h5, 8'h00);
    cycle();
    saved = ack_cnt[1][0];
    reset_inst(1);
    issue(1, 1, 1'b0, 4'h5, 8'h00);
    run(2);
    rst_n[1] = 1'b1;
    wait_ack(1, 1, 20, n);
    check_val("post_rst_latency", n, 4);
    check_val("post_rst_rdata1", rdata[1][1], 8'hB7);
    check_val("post_rst_no_m0_ack", ack_cnt[1][0] - saved, 0);
    run(4);

    // Randomized traffic with occasional mid-flight resets
    for (int g = 0; g < 2; g++) begin
      for (int a = 0; a < 16; a++)
        dev_tab[g][a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      mode[g][0] = 1; mode[g][1] = 1;
    end
    for (int i = 0; i < 3000; i++) begin
      cycle();
      for (int g = 0; g < 2; g++) begin
        if (!rst_n[g]) rst_n[g] = 1'b1;
        else if ($urandom_range(0, 399) == 0) reset_inst(g);
      end
    end
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b1;
      mode[g][0] = 0; mode[g][1] = 0;
    end
    run(40);
    check_val("drain_busy0", busy[0], 0);
    check_val("drain_busy1", busy[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
